// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared widths, ctrl bit positions, stage records and forwarding encodings
package hazard_ctrl_pkg;

   // Register index width and per-stage control widths
   localparam int REG_W      = 5;
   localparam int EX_CTRL_W  = 7;
   localparam int MEM_CTRL_W = 4;
   localparam int WB_CTRL_W  = 2;
   localparam int CNT_W      = 16;

   // Decoded ID control layout {ALUOp[1:0], ALUSrc, RegWrite, MemtoReg, MemRead, MemWrite}
   localparam int CTRL_ALUOP_HI = 6;
   localparam int CTRL_ALUOP_LO = 5;
   localparam int CTRL_ALUSRC   = 4;
   localparam int CTRL_REGWRITE = 3;
   localparam int CTRL_MEMTOREG = 2;
   localparam int CTRL_MEMREAD  = 1;
   localparam int CTRL_MEMWRITE = 0;

   // MEM stage control layout {RegWrite, MemtoReg, MemRead, MemWrite}
   localparam int MEM_REGWRITE = 3;
   localparam int MEM_MEMTOREG = 2;
   localparam int MEM_MEMREAD  = 1;
   localparam int MEM_MEMWRITE = 0;

   // WB stage control layout {RegWrite, MemtoReg}
   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;

   // EX operand source select
   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwdSel_e;

   typedef struct packed {
      logic [EX_CTRL_W-1:0] ctrl;
      logic [REG_W-1:0]     rd;
      logic [REG_W-1:0]     rs1;
      logic [REG_W-1:0]     rs2;
   } exStage_t;

   typedef struct packed {
      logic [MEM_CTRL_W-1:0] ctrl;
      logic [REG_W-1:0]      rd;
   } memStage_t;

   typedef struct packed {
      logic [WB_CTRL_W-1:0] ctrl;
      logic [REG_W-1:0]     rd;
   } wbStage_t;

   // A producer index matches a consumer index only when it is not x0
   function automatic logic regMatch(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs);
      return (rd != '0) && (rd == rs);
   endfunction

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// rtl/hazard_ctrl_forward_unit.sv - combinational EX operand forwarding select
module forward_unit
   import hazard_ctrl_pkg::*;
(
   input  logic             memRegWrite,
   input  logic [REG_W-1:0] memRd,
   input  logic             wbRegWrite,
   input  logic [REG_W-1:0] wbRd,
   input  logic [REG_W-1:0] exRs1,
   input  logic [REG_W-1:0] exRs2,
   output logic [1:0]       forwardA,
   output logic [1:0]       forwardB
);

   // MEM is the younger producer, so it is checked first
   function automatic fwdSel_e selectFwd(input logic [REG_W-1:0] rs);
      if (memRegWrite && regMatch(memRd, rs)) begin
         return FWD_MEM;
      end
      if (wbRegWrite && regMatch(wbRd, rs)) begin
         return FWD_WB;
      end
      return FWD_REG;
   endfunction

   // Pick the operand source for both EX read ports
   always_comb begin
      forwardA = selectFwd(exRs1);
      forwardB = selectFwd(exRs2);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline control registers, load-use stall, branch flush and forwarding
module hazard_ctrl
   import hazard_ctrl_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [EX_CTRL_W-1:0] id_ctrl_i,
   input  logic [REG_W-1:0]     id_rs1_i,
   input  logic [REG_W-1:0]     id_rs2_i,
   input  logic [REG_W-1:0]     id_rd_i,
   input  logic                 id_branch_taken_i,
   output logic                 noop_o,
   output logic                 pc_write_o,
   output logic                 ifid_write_o,
   output logic                 ifid_flush_o,
   output logic [2:0]           ex_ctrl_o,
   output logic [1:0]           mem_ctrl_o,
   output logic [1:0]           wb_ctrl_o,
   output logic [REG_W-1:0]     ex_rd_o,
   output logic [REG_W-1:0]     mem_rd_o,
   output logic [REG_W-1:0]     wb_rd_o,
   output logic [1:0]           forward_a_o,
   output logic [1:0]           forward_b_o,
   output logic [CNT_W-1:0]     stall_cnt_o
);

   exStage_t         exQ;
   memStage_t        memQ;
   wbStage_t         wbQ;
   logic [CNT_W-1:0] stallCnt;
   logic             hazard;

   // Load in EX whose destination is read by the instruction in ID
   always_comb begin
      hazard = exQ.ctrl[CTRL_MEMREAD]
             & (regMatch(exQ.rd, id_rs1_i) | regMatch(exQ.rd, id_rs2_i));
   end

   // Front-end enables; reset freezes the front end, a stall beats a flush
   always_comb begin
      if (rst_i) begin
         noop_o       = 1'b1;
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
         ifid_flush_o = 1'b0;
      end else begin
         noop_o       = hazard;
         pc_write_o   = ~hazard;
         ifid_write_o = ~hazard;
         ifid_flush_o = id_branch_taken_i & ~hazard;
      end
   end

   // Stage registers advance every cycle; a stall inserts a bubble into EX
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         exQ  <= '0;
         memQ <= '0;
         wbQ  <= '0;
      end else begin
         if (hazard) begin
            exQ <= '0;
         end else begin
            exQ.ctrl <= id_ctrl_i;
            exQ.rd   <= id_rd_i;
            exQ.rs1  <= id_rs1_i;
            exQ.rs2  <= id_rs2_i;
         end
         memQ.ctrl <= {exQ.ctrl[CTRL_REGWRITE], exQ.ctrl[CTRL_MEMTOREG],
                       exQ.ctrl[CTRL_MEMREAD], exQ.ctrl[CTRL_MEMWRITE]};
         memQ.rd   <= exQ.rd;
         wbQ.ctrl  <= {memQ.ctrl[MEM_REGWRITE], memQ.ctrl[MEM_MEMTOREG]};
         wbQ.rd    <= memQ.rd;
      end
   end

   // Saturating count of load-use stall cycles
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stallCnt <= '0;
      end else if (hazard && (stallCnt != '1)) begin
         stallCnt <= stallCnt + 1'b1;
      end
   end

   assign ex_ctrl_o   = {exQ.ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO], exQ.ctrl[CTRL_ALUSRC]};
   assign mem_ctrl_o  = {memQ.ctrl[MEM_MEMREAD], memQ.ctrl[MEM_MEMWRITE]};
   assign wb_ctrl_o   = {wbQ.ctrl[WB_REGWRITE], wbQ.ctrl[WB_MEMTOREG]};
   assign ex_rd_o     = exQ.rd;
   assign mem_rd_o    = memQ.rd;
   assign wb_rd_o     = wbQ.rd;
   assign stall_cnt_o = stallCnt;

   forward_unit uForward (
      .memRegWrite (memQ.ctrl[MEM_REGWRITE]),
      .memRd       (memQ.rd),
      .wbRegWrite  (wbQ.ctrl[WB_REGWRITE]),
      .wbRd        (wbQ.rd),
      .exRs1       (exQ.rs1),
      .exRs2       (exQ.rs2),
      .forwardA    (forward_a_o),
      .forwardB    (forward_b_o)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector bench for hazard_ctrl
module tb_hazard_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [6:0]  id_ctrl_i;
   logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
   logic        id_branch_taken_i;
   logic        noop_o, pc_write_o, ifid_write_o, ifid_flush_o;
   logic [2:0]  ex_ctrl_o;
   logic [1:0]  mem_ctrl_o, wb_ctrl_o;
   logic [4:0]  ex_rd_o, mem_rd_o, wb_rd_o;
   logic [1:0]  forward_a_o, forward_b_o;
   logic [15:0] stall_cnt_o;

   int checks = 0;
   int errors = 0;

   localparam int NVEC = 23;

   // Encodings {ALUOp, ALUSrc, RegWrite, MemtoReg, MemRead, MemWrite}
   localparam logic [6:0] LW  = 7'h1E;
   localparam logic [6:0] ADD = 7'h48;
   localparam logic [6:0] SW  = 7'h11;
   localparam logic [6:0] NOP = 7'h00;

   typedef struct packed {
      logic        rst;
      logic [6:0]  ctrl;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        br;
      logic [45:0] exp;
   } vec_t;

   vec_t vecs [NVEC];

   always #5 clk_i = ~clk_i;

   hazard_ctrl dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .id_ctrl_i         (id_ctrl_i),
      .id_rs1_i          (id_rs1_i),
      .id_rs2_i          (id_rs2_i),
      .id_rd_i           (id_rd_i),
      .id_branch_taken_i (id_branch_taken_i),
      .noop_o            (noop_o),
      .pc_write_o        (pc_write_o),
      .ifid_write_o      (ifid_write_o),
      .ifid_flush_o      (ifid_flush_o),
      .ex_ctrl_o         (ex_ctrl_o),
      .mem_ctrl_o        (mem_ctrl_o),
      .wb_ctrl_o         (wb_ctrl_o),
      .ex_rd_o           (ex_rd_o),
      .mem_rd_o          (mem_rd_o),
      .wb_rd_o           (wb_rd_o),
      .forward_a_o       (forward_a_o),
      .forward_b_o       (forward_b_o),
      .stall_cnt_o       (stall_cnt_o)
   );

   function automatic vec_t mk(
      input logic rst, input logic [6:0] ctrl, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [4:0] rd, input logic br, input logic noop, input logic flush,
      input logic [2:0] exC, input logic [1:0] memC, input logic [1:0] wbC,
      input logic [4:0] exRd, input logic [4:0] memRd, input logic [4:0] wbRd,
      input logic [1:0] fa, input logic [1:0] fb, input logic [15:0] cnt);
      vec_t v;
      v.rst  = rst;
      v.ctrl = ctrl;
      v.rs1  = rs1;
      v.rs2  = rs2;
      v.rd   = rd;
      v.br   = br;
      v.exp  = {noop, ~noop, ~noop, flush, exC, memC, wbC, exRd, memRd, wbRd, fa, fb, cnt};
      return v;
   endfunction

   function automatic logic [45:0] actual();
      return {noop_o, pc_write_o, ifid_write_o, ifid_flush_o, ex_ctrl_o, mem_ctrl_o, wb_ctrl_o,
              ex_rd_o, mem_rd_o, wb_rd_o, forward_a_o, forward_b_o, stall_cnt_o};
   endfunction

   task automatic drive(input logic rst, input logic [6:0] ctrl, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic br);
      rst_i             = rst;
      id_ctrl_i         = ctrl;
      id_rs1_i          = rs1;
      id_rs2_i          = rs2;
      id_rd_i           = rd;
      id_branch_taken_i = br;
   endtask

   task automatic check16(input string name, input logic [15:0] got, input logic [15:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic check1(input string name, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %b want %b", name, got, want);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [45:0] got;

      //          rst   ctrl rs1    rs2    rd     br    noop  flush exC     memC   wbC    exRd   memRd  wbRd   fa     fb     cnt
      vecs[0]  = mk(1'b1, LW,  5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b000, 2'b00, 2'b00, 5'd0,  5'd0,  5'd0,  2'b00, 2'b00, 16'd0);
      vecs[1]  = mk(1'b0, LW,  5'd1, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 5'd0,  5'd0,  5'd0,  2'b00, 2'b00, 16'd0);
      vecs[2]  = mk(1'b0, ADD, 5'd5, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0, 3'b001, 2'b00, 2'b00, 5'd5,  5'd0,  5'd0,  2'b00, 2'b00, 16'd0);
      vecs[3]  = mk(1'b0, ADD, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0, 1'b1, 3'b000, 2'b10, 2'b00, 5'd0,  5'd5,  5'd0,  2'b00, 2'b00, 16'd1);
      vecs[4]  = mk(1'b0, ADD, 5'd6, 5'd5, 5'd7, 1'b0, 1'b0, 1'b0, 3'b100, 2'b00, 2'b11, 5'd6,  5'd0,  5'd5,  2'b01, 2'b00, 16'd1);
      vecs[5]  = mk(1'b0, ADD, 5'd1, 5'd1, 5'd3, 1'b0, 1'b0, 1'b0, 3'b100, 2'b00, 2'b00, 5'd7,  5'd6,  5'd0,  2'b10, 2'b00, 16'd1);
      vecs[6]  = mk(1'b0, ADD, 5'd2, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 3'b100, 2'b00, 2'b10, 5'd3,  5'd7,  5'd6,  2'b00, 2'b00, 16'd1);
      vecs[7]  = mk(1'b0, ADD, 5'd3, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0, 3'b100, 2'b00, 2'b10, 5'd3,  5'd3,  5'd7,  2'b00, 2'b00, 16'd1);
      vecs[8]  = mk(1'b0, SW,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b100, 2'b00, 2'b10, 5'd8,  5'd3,  5'd3,  2'b10, 2'b10, 16'd1);
      vecs[9]  = mk(1'b0, ADD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b001, 2'b00, 2'b10, 5'd0,  5'd8,  5'd3,  2'b00, 2'b00, 16'd1);
      vecs[10] = mk(1'b0, LW,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b100, 2'b01, 2'b10, 5'd0,  5'd0,  5'd8,  2'b00, 2'b00, 16'd1);
      vecs[11] = mk(1'b0, ADD, 5'd0, 5'd0, 5'd10, 1'b0, 1'b0, 1'b0, 3'b001, 2'b00, 2'b00, 5'd0, 5'd0,  5'd0,  2'b00, 2'b00, 16'd1);
      vecs[12] = mk(1'b0, LW,  5'd1, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 3'b100, 2'b10, 2'b10, 5'd10, 5'd0,  5'd0,  2'b00, 2'b00, 16'd1);
      vecs[13] = mk(1'b0, LW,  5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 3'b001, 2'b00, 2'b11, 5'd5,  5'd10, 5'd0,  2'b00, 2'b00, 16'd1);
      vecs[14] = mk(1'b0, LW,  5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 3'b000, 2'b10, 2'b10, 5'd0,  5'd5,  5'd10, 2'b00, 2'b00, 16'd2);
      vecs[15] = mk(1'b0, ADD, 5'd5, 5'd0, 5'd1, 1'b0, 1'b1, 1'b0, 3'b001, 2'b00, 2'b11, 5'd5,  5'd0,  5'd5,  2'b01, 2'b00, 16'd2);
      vecs[16] = mk(1'b0, ADD, 5'd5, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b10, 2'b00, 5'd0,  5'd5,  5'd0,  2'b00, 2'b00, 16'd3);
      vecs[17] = mk(1'b0, LW,  5'd1, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0, 3'b100, 2'b00, 2'b11, 5'd1,  5'd0,  5'd5,  2'b01, 2'b00, 16'd3);
      vecs[18] = mk(1'b1, ADD, 5'd4, 5'd4, 5'd6, 1'b0, 1'b1, 1'b0, 3'b001, 2'b00, 2'b00, 5'd4,  5'd1,  5'd0,  2'b10, 2'b00, 16'd3);
      vecs[19] = mk(1'b0, ADD, 5'd4, 5'd4, 5'd6, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 5'd0,  5'd0,  5'd0,  2'b00, 2'b00, 16'd0);
      vecs[20] = mk(1'b0, NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b100, 2'b00, 2'b00, 5'd6,  5'd0,  5'd0,  2'b00, 2'b00, 16'd0);
      vecs[21] = mk(1'b0, NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 5'd0,  5'd6,  5'd0,  2'b00, 2'b00, 16'd0);
      vecs[22] = mk(1'b0, NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b10, 5'd0,  5'd0,  5'd6,  2'b00, 2'b00, 16'd0);

      drive(1'b1, NOP, 5'd0, 5'd0, 5'd0, 1'b0);
      repeat (2) @(posedge clk_i);

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk_i);
         drive(vecs[i].rst, vecs[i].ctrl, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].br);
         #1;
         got = actual();
         checks++;
         if (got !== vecs[i].exp) begin
            errors++;
            $display("FAIL vec%0d got %h want %h", i, got, vecs[i].exp);
         end
      end

      // Counter saturation from a preloaded value near the top
      @(negedge clk_i);
      drive(1'b0, NOP, 5'd0, 5'd0, 5'd0, 1'b0);
      force dut.stallCnt = 16'hFFFE;
      #1;
      release dut.stallCnt;
      #1;
      check16("cnt_preload", stall_cnt_o, 16'hFFFE);
      for (int s = 0; s < 3; s++) begin
         @(negedge clk_i);
         drive(1'b0, LW, 5'd0, 5'd0, 5'd5, 1'b0);
         @(negedge clk_i);
         drive(1'b0, ADD, 5'd5, 5'd0, 5'd9, 1'b0);
         #1;
         check1($sformatf("sat_stall%0d", s), noop_o, 1'b1);
         @(posedge clk_i);
         #1;
         check16($sformatf("sat_cnt%0d", s), stall_cnt_o, 16'hFFFF);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
